// File: rtl/cyc_gen_pkg.sv
// Shared types and constants for the single-transaction bus cycle generator.
package cyc_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RECOVER = 2'd2
  } cyc_state_t;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/cyc_gen.sv
// Issues one bus cycle per accepted command, waits for an ID-matched ack or a
// timeout, then holds off new commands until the responder releases ack.
module cyc_gen
  import cyc_gen_pkg::*;
#(
  parameter int   WID       = 6,
  parameter int   TIMEOUT   = 20,
  parameter logic ACK_LEVEL = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [WID-1:0]       id_i,
  output logic                 rdy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [WID-1:0]       done_id_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [WID-1:0]       id_o,
  input  logic                 ack_i,
  input  logic [WID-1:0]       rid_i,
  input  logic [WID-1:0]       wid_i
);

  // Keep the timer at least one bit wide so TIMEOUT=0 still elaborates.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TLAST);

  cyc_state_t           r_state,   w_state;
  logic [TW-1:0]        r_timer,   w_timer;
  logic                 r_cyc,     w_cyc;
  logic                 r_stb,     w_stb;
  logic                 r_we,      w_we;
  logic [WID-1:0]       r_id,      w_id;
  logic                 r_rdy,     w_rdy;
  logic                 r_done,    w_done;
  logic                 r_err,     w_err;
  logic [WID-1:0]       r_done_id, w_done_id;
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt;

  logic w_match;
  logic w_ack_idle;

  assign w_match    = ack_i && ((r_we ? wid_i : rid_i) == r_id);
  assign w_ack_idle = (ack_i == ACK_LEVEL) || !ack_i;

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_cyc     = r_cyc;
    w_stb     = r_stb;
    w_we      = r_we;
    w_id      = r_id;
    w_rdy     = r_rdy;
    w_done    = 1'b0;   // pulses self-clear on every clock, ce or not
    w_err     = 1'b0;
    w_done_id = r_done_id;
    w_err_cnt = r_err_cnt;
    if (ce_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            w_we    = we_i;
            w_id    = id_i;
            w_cyc   = 1'b1;
            w_stb   = 1'b1;
            w_rdy   = 1'b0;
            w_timer = '0;
            w_state = ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // A matching ack takes priority over the terminal timer cycle.
          if (w_match) begin
            w_cyc     = 1'b0;
            w_stb     = 1'b0;
            w_done    = 1'b1;
            w_done_id = r_id;
            w_state   = ST_RECOVER;
          end else if ((TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
            w_cyc     = 1'b0;
            w_stb     = 1'b0;
            w_done    = 1'b1;
            w_err     = 1'b1;
            w_done_id = r_id;
            if (r_err_cnt != '1) w_err_cnt = r_err_cnt + 1'b1;
            w_state   = ST_RECOVER;
          end else if (TIMEOUT != 0) begin
            w_timer = r_timer + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (w_ack_idle) begin
            w_rdy   = 1'b1;
            w_state = ST_IDLE;
          end
        end
        default: begin
          w_rdy   = 1'b1;
          w_cyc   = 1'b0;
          w_stb   = 1'b0;
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_id      <= '0;
      r_rdy     <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_done_id <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_cyc     <= w_cyc;
      r_stb     <= w_stb;
      r_we      <= w_we;
      r_id      <= w_id;
      r_rdy     <= w_rdy;
      r_done    <= w_done;
      r_err     <= w_err;
      r_done_id <= w_done_id;
      r_err_cnt <= w_err_cnt;
    end
  end

  assign rdy_o     = r_rdy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign done_id_o = r_done_id;
  assign err_cnt_o = r_err_cnt;
  assign cyc_o     = r_cyc;
  assign stb_o     = r_stb;
  assign we_o      = r_we;
  assign id_o      = r_id;

endmodule

// File: tb/tb_cyc_gen.sv
// Directed bench for cyc_gen: completion, ID filtering, timeout, held ack,
// reset mid-cycle and clock-enable stalls.
module tb_cyc_gen;

  localparam int WID = 6;
  localparam int TIMEOUT = 20;

  logic            clk = 1'b0;
  logic            rst, ce, req, we, ack;
  logic [WID-1:0]  id, rid, wid;
  logic            rdy, done, err, cyc, stb, we_o;
  logic [WID-1:0]  done_id, id_o;
  logic [15:0]     err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  cyc_gen #(.WID(WID), .TIMEOUT(TIMEOUT), .ACK_LEVEL(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .we_i(we), .id_i(id),
    .rdy_o(rdy), .done_o(done), .err_o(err), .done_id_o(done_id),
    .err_cnt_o(err_cnt), .cyc_o(cyc), .stb_o(stb), .we_o(we_o), .id_o(id_o),
    .ack_i(ack), .rid_i(rid), .wid_i(wid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [WID-1:0] i);
    req = 1'b1; we = w; id = i;
    tick();
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; req = 1'b0; we = 1'b0; id = '0;
    ack = 1'b0; rid = '0; wid = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdy", rdy, 1); chk("rst_cyc", cyc, 0); chk("rst_stb", stb, 0);
    chk("rst_we", we_o, 0); chk("rst_id", id_o, 0); chk("rst_done", done, 0);
    chk("rst_err", err, 0); chk("rst_done_id", done_id, 0); chk("rst_errcnt", err_cnt, 0);

    // Read id=5, ack three cycles after cyc rises
    issue(1'b0, 6'd5);
    chk("rd_cyc", cyc, 1); chk("rd_stb", stb, 1); chk("rd_rdy", rdy, 0);
    chk("rd_id", id_o, 5); chk("rd_we", we_o, 0);
    tick(); tick();
    ack = 1'b1; rid = 6'd5;
    tick();
    chk("rd_done", done, 1); chk("rd_err", err, 0); chk("rd_done_id", done_id, 5);
    chk("rd_cyc_lo", cyc, 0); chk("rd_stb_lo", stb, 0); chk("rd_rdy_rec", rdy, 0);
    ack = 1'b0; ce = 1'b0;
    tick();
    chk("done_clr_noce", done, 0); chk("rdy_hold_noce", rdy, 0);
    ce = 1'b1;
    tick();
    chk("rd_rdy_back", rdy, 1);

    // Write id=9, wrong-ID ack first
    issue(1'b1, 6'd9);
    chk("wr_we", we_o, 1);
    ack = 1'b1; wid = 6'd8;
    tick();
    chk("wr_ign_done", done, 0); chk("wr_ign_cyc", cyc, 1);
    wid = 6'd9;
    tick();
    chk("wr_done", done, 1); chk("wr_err", err, 0); chk("wr_done_id", done_id, 9);
    ack = 1'b0;
    tick();
    chk("wr_rdy", rdy, 1);

    // Timeout: read id=3, no ack
    issue(1'b0, 6'd3);
    n = 0;
    while (cyc && n < 100) begin n++; tick(); end
    chk("to_cyc_len", n, 20); chk("to_done", done, 1); chk("to_err", err, 1);
    chk("to_errcnt", err_cnt, 1); chk("to_done_id", done_id, 3);
    tick();
    chk("to_done_clr", done, 0); chk("to_err_clr", err, 0); chk("to_rdy", rdy, 1);

    // Matching ack on the terminal timer cycle
    issue(1'b0, 6'd7);
    for (int k = 0; k < 19; k++) tick();
    chk("term_cyc", cyc, 1); chk("term_pre_done", done, 0);
    ack = 1'b1; rid = 6'd7;
    tick();
    chk("term_done", done, 1); chk("term_err", err, 0); chk("term_errcnt", err_cnt, 1);
    ack = 1'b0;
    tick();
    chk("term_rdy", rdy, 1);

    // Held ack after completion; req during recovery must be dropped
    issue(1'b0, 6'd2);
    ack = 1'b1; rid = 6'd2;
    tick();
    chk("hold_done", done, 1);
    req = 1'b1; id = 6'd11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("hold_rdy", rdy, 0); chk("hold_cyc", cyc, 0);
    end
    ack = 1'b0; req = 1'b0;
    tick();
    chk("hold_rdy_back", rdy, 1); chk("hold_noq_cyc", cyc, 0);
    tick();
    chk("hold_noq_cyc2", cyc, 0);

    // ce low in IDLE blocks acceptance
    ce = 1'b0; req = 1'b1; id = 6'd1;
    tick();
    chk("noce_cyc", cyc, 0); chk("noce_rdy", rdy, 1);
    ce = 1'b1; req = 1'b0;

    // Reset two cycles into ACTIVE
    issue(1'b0, 6'd4);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_cyc", cyc, 0); chk("mrst_stb", stb, 0); chk("mrst_rdy", rdy, 1);
    chk("mrst_id", id_o, 0); chk("mrst_done", done, 0); chk("mrst_errcnt", err_cnt, 0);
    tick();
    chk("mrst_done2", done, 0);

    // ce low 5 cycles inside ACTIVE stretches the timeout to 25
    issue(1'b0, 6'd6);
    n = 0;
    while (cyc && n < 100) begin
      ce = !(n >= 5 && n < 10);
      n++;
      tick();
    end
    ce = 1'b1;
    chk("ce_cyc_len", n, 25); chk("ce_done", done, 1); chk("ce_err", err, 1);
    chk("ce_errcnt", err_cnt, 1); chk("ce_done_id", done_id, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cyc_gen.md
CYC_GEN -- requirements
Module: cyc_gen

Interface
REQ-001 Parameter WID, default 6: width of transaction ID fields.
REQ-002 Parameter TIMEOUT, default 20: clocks (ce-qualified) to wait for ack before aborting; 0 disables timeout.
REQ-003 Parameter ACK_LEVEL, default 1'b0: idle level the responder drives on ack_i when not selected.
REQ-004 Port clk_i  in  1: the single clock; all state updates on its rising edge.
REQ-005 Port rst_i  in  1: reset; synchronous, active-high.
REQ-006 Port ce_i  in  1: clock enable; when low, all state holds.
REQ-007 Port req_i  in  1: command request, sampled only when rdy_o=1.
REQ-008 Port we_i  in  1: command is a write (1) or read (0).
REQ-009 Port id_i  in  WID: command transaction ID.
REQ-010 Port rdy_o  out  1: block idle, can accept a command.
REQ-011 Port done_o  out  1: one-clock pulse, transaction finished.
REQ-012 Port err_o  out  1: qualifies done_o; 1 = aborted by timeout.
REQ-013 Port done_id_o  out  WID: ID of finished transaction, valid with done_o.
REQ-014 Port err_cnt_o  out  16: saturating count of timeouts.
REQ-015 Port cyc_o, stb_o, we_o  out  1 each: bus cycle, strobe, write enable to responder.
REQ-016 Port id_o  out  WID: ID presented with the bus cycle.
REQ-017 Port ack_i  in  1: responder acknowledge.
REQ-018 Port rid_i, wid_i  in  WID each: read / write ID returned with ack.

Function
REQ-019 All outputs registered; FSM states IDLE, ACTIVE, RECOVER.
REQ-020 IDLE: rdy_o=1, cyc_o=stb_o=0; on ce_i&req_i, latch we_i/id_i into we_o/id_o, set cyc_o=stb_o=1, clear timer, enter ACTIVE; cyc_o high the cycle after acceptance.
REQ-021 req_i while rdy_o=0 is ignored, never queued.
REQ-022 ACTIVE: matching ack = ack_i!=ACK_LEVEL... defined as ack_i=1 and (we_o ? wid_i : rid_i)==id_o.
REQ-023 ACTIVE: on matching ack, next cycle cyc_o=stb_o=0, done_o=1, err_o=0, done_id_o=id_o, enter RECOVER.
REQ-024 ACTIVE: ack_i=1 with non-matching ID ignored; timer keeps running.
REQ-025 ACTIVE: timer increments each ce cycle; when timer==TIMEOUT-1 with no matching ack, next cycle cyc_o=stb_o=0, done_o=1, err_o=1, done_id_o=id_o, err_cnt_o+1 (saturate 16'hFFFF), enter RECOVER.
REQ-026 Matching ack on the terminal timer cycle wins: success, err_o=0, no err_cnt_o increment.
REQ-027 Timer width $clog2(TIMEOUT+1); TIMEOUT=0: never abort.
REQ-028 RECOVER: rdy_o=0; when ack_i==ACK_LEVEL or ack_i=0, enter IDLE (rdy_o=1 next cycle); protects against held acks.
REQ-029 done_o, err_o high for exactly one clock; cleared on any following clock regardless of ce_i.
REQ-030 ce_i low: FSM, timer, bus outputs, err_cnt_o hold.

Reset
REQ-031 rst_i=1 at a clock edge: state IDLE, rdy_o=1, cyc_o=stb_o=we_o=0, id_o=0, done_o=err_o=0, done_id_o=0, err_cnt_o=0, timer=0; overrides ce_i.
REQ-032 Reset mid-ACTIVE drops cyc_o/stb_o next edge with no done_o pulse.

Structure
REQ-033 Package cyc_gen_pkg holds the state enum typedef (IDLE, ACTIVE, RECOVER) and the error-counter width constant (16).
REQ-034 No sub-module; timer and error counter inline.

Verification
REQ-035 WID=6, TIMEOUT=20: req id=5 read; rid_i=5 ack 3 cycles after cyc_o -> cyc_o low, done_o=1, err_o=0, done_id_o=5, rdy_o=1 one cycle after ack_i falls.
REQ-036 Write id=9; ack_i with wid_i=8 then wid_i=9 -> first ignored, completes on second, err_o=0.
REQ-037 Read id=3, no ack -> cyc_o high exactly 20 clocks, done_o=err_o=1, err_cnt_o=1.
REQ-038 Ack matching on terminal timer cycle -> err_o=0, err_cnt_o unchanged.
REQ-039 ack_i held high 4 cycles after completion -> rdy_o stays 0 until ack_i=0; req_i during RECOVER ignored.
REQ-040 rst_i asserted 2 cycles into ACTIVE -> all outputs at reset values next edge, no done_o; ce_i low 5 cycles in ACTIVE extends timeout by 5.
